// File: rtl/instr_sequencer_pkg.sv
// rv_ctrl_pkg: shared constants for the instruction sequencer.
// Holds RV32 opcode/funct constants, the alu_control encodings driven toward
// the datapath, the sequencer state enum, instruction field bit positions and
// the branch-immediate extraction helper.
package rv_ctrl_pkg;

  // Major opcodes
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // funct3 / funct7 values
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alu_control encodings understood by the datapath
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Instruction field LSB positions
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT
  } state_t;

  // B-type immediate, 13 bits with the implicit zero LSB; caller sign-extends.
  function automatic logic [12:0] branch_imm(input logic [31:0] instr);
    return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-memory request/acknowledge port.
//   req   - fetch request (sequencer -> memory)
//   addr  - fetch address, PC_W bits (sequencer -> memory)
//   ack   - instruction word valid this cycle (memory -> sequencer)
//   rdata - 32-bit instruction word (memory -> sequencer)
interface instr_sequencer_if #(
  parameter int PC_W = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_sequencer_alu_decoder.sv
// alu_decoder: combinational (opcode, funct3, funct7) -> {alu_control, legal}.
//   opcode/funct3/funct7 in - fields of the held instruction register
//   alu_control          out - datapath ALU operation (ADD when not decoded)
//   legal                out - instruction is a supported R-type, BEQ or BNE
// SYSTEM opcodes report legal=0; the sequencer treats them as a clean halt.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_control = ALU_ADD;
          {F7_ALT,  3'b000}: alu_control = ALU_SUB;
          {F7_BASE, 3'b111}: alu_control = ALU_AND;
          {F7_BASE, 3'b110}: alu_control = ALU_OR;
          {F7_BASE, 3'b100}: alu_control = ALU_XOR;
          {F7_BASE, 3'b001}: alu_control = ALU_SLL;
          {F7_BASE, 3'b101}: alu_control = ALU_SRL;
          {F7_ALT,  3'b101}: alu_control = ALU_SRA;
          {F7_BASE, 3'b010}: alu_control = ALU_SLT;
          {F7_BASE, 3'b011}: alu_control = ALU_SLTU;
          default:           legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        // The branch compares rs1-rs2 and resolves on zero_flag.
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          alu_control = ALU_SUB;
          legal       = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle PC/control owner for a register-file/ALU datapath.
// Fetches over a req/ack memory port, decodes R-type and BEQ/BNE, sequences
// the datapath controls and resolves branches from zero_flag.
//   clock, reset      - single clock, synchronous active-high reset
//   start             - leaves IDLE, or restarts from RESET_PC out of HALT
//   imem              - instruction fetch port (master side)
//   read_reg_num1/2   - rs1/rs2 from ir; write_reg - rd from ir
//   alu_control       - ALU op; regwrite - one-cycle write enable in EXECUTE
//   zero_flag         - datapath ALU result == 0
//   pc, busy, halted, illegal (sticky), instret (retired count)
// Every datapath control is decoded from registered state/ir only.
module instr_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  instr_sequencer_if.master imem,
  output logic [4:0]        read_reg_num1,
  output logic [4:0]        read_reg_num2,
  output logic [4:0]        write_reg,
  output logic [3:0]        alu_control,
  output logic              regwrite,
  input  logic              zero_flag,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       instret
);

  localparam int EXT_W = PC_W - 13;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [31:0]     ir_reg, ir_next;
  logic [31:0]     instret_reg, instret_next;
  logic            illegal_reg, illegal_next;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [3:0]      dec_alu;
  logic            dec_legal;
  logic [12:0]     imm;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] branch_target;
  logic            branch_taken;

  assign opcode = ir_reg[OPC_LSB +: 7];
  assign funct3 = ir_reg[F3_LSB +: 3];
  assign funct7 = ir_reg[F7_LSB +: 7];

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  // Target is formed from the branch's own pc, which is still in pc_reg
  // during EXECUTE; all arithmetic wraps at PC_W bits.
  assign imm           = branch_imm(ir_reg);
  assign pc_plus4      = pc_reg + {{(PC_W-3){1'b0}}, 3'b100};
  assign branch_target = pc_reg + {{EXT_W{imm[12]}}, imm};
  // funct3[0] distinguishes BNE from BEQ
  assign branch_taken  = funct3[0] ? ~zero_flag : zero_flag;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      instret_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      instret_reg <= instret_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    instret_next = instret_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.ack) begin
          ir_next    = imem.rdata;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_next = ST_HALT;
        end else if (dec_legal) begin
          state_next = ST_EXECUTE;
        end else begin
          illegal_next = 1'b1;
          state_next   = ST_HALT;
        end
      end
      ST_EXECUTE: begin
        if (opcode == OP_BRANCH && branch_taken) begin
          if (branch_target[1]) begin
            // Misaligned target: stop without retiring or moving pc.
            illegal_next = 1'b1;
            state_next   = ST_HALT;
          end else begin
            pc_next      = branch_target;
            instret_next = instret_reg + 32'd1;
            state_next   = ST_FETCH;
          end
        end else begin
          pc_next      = pc_plus4;
          instret_next = instret_reg + 32'd1;
          state_next   = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (start) begin
          illegal_next = 1'b0;
          pc_next      = RESET_PC;
          state_next   = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign imem.req      = (state_reg == ST_FETCH);
  assign imem.addr     = pc_reg;
  assign read_reg_num1 = ir_reg[RS1_LSB +: 5];
  assign read_reg_num2 = ir_reg[RS2_LSB +: 5];
  assign write_reg     = ir_reg[RD_LSB +: 5];
  assign alu_control   = dec_alu;
  // Only legal R-types reach EXECUTE with OP_RTYPE; writes to x0 are dropped.
  assign regwrite      = (state_reg == ST_EXECUTE) && (opcode == OP_RTYPE)
                         && (ir_reg[RD_LSB +: 5] != 5'd0);
  assign pc            = pc_reg;
  assign busy          = (state_reg == ST_FETCH) || (state_reg == ST_DECODE)
                         || (state_reg == ST_EXECUTE);
  assign halted        = (state_reg == ST_HALT);
  assign illegal       = illegal_reg;
  assign instret       = instret_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        zero_flag = 1'b0;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [3:0]  alu_control;
  logic        regwrite, busy, halted, illegal;
  logic [31:0] pc, instret;

  instr_sequencer_if #(.PC_W(32)) imem_bus ();

  instr_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .imem          (imem_bus),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .write_reg     (write_reg),
    .alu_control   (alu_control),
    .regwrite      (regwrite),
    .zero_flag     (zero_flag),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .illegal       (illegal),
    .instret       (instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instret;
    logic        rw;
    logic [4:0]  rd;
    logic [3:0]  alu;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_instret = 32'h0;

  // Observations captured by drive_fetch at each phase of one instruction
  logic [31:0] ob_addr;
  logic        ob_stable;
  logic [4:0]  ob_dec_rs1, ob_dec_rs2;
  logic [3:0]  ob_dec_alu, ob_ex_alu;
  logic        ob_dec_req, ob_dec_rw, ob_ex_rw, ob_ex_halted, ob_ex_illegal;
  logic [4:0]  ob_ex_rd;
  logic [31:0] ob_post_pc, ob_post_instret;
  logic        ob_post_rw, ob_post_req, ob_post_illegal, ob_post_halted;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Serve one fetch after 'waits' idle cycles, then observe DECODE, EXECUTE
  // and the cycle after EXECUTE.
  task automatic drive_fetch(input logic [31:0] word, input logic zf, input int waits);
    int guard = 0;
    while (imem_bus.req !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (imem_bus.req !== 1'b1) begin
      n_vec++; n_miss++;
      $display("FAIL fetch_timeout imem_req=%b required=1", imem_bus.req);
    end
    ob_addr   = imem_bus.addr;
    ob_stable = 1'b1;
    for (int i = 0; i < waits; i++) begin
      imem_bus.ack = 1'b0;
      tick();
      if (imem_bus.req !== 1'b1 || imem_bus.addr !== ob_addr || pc !== ob_addr || busy !== 1'b1)
        ob_stable = 1'b0;
    end
    imem_bus.rdata = word;
    imem_bus.ack   = 1'b1;
    zero_flag      = zf;
    tick();
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;
    ob_dec_rs1 = read_reg_num1;
    ob_dec_rs2 = read_reg_num2;
    ob_dec_alu = alu_control;
    ob_dec_req = imem_bus.req;
    ob_dec_rw  = regwrite;
    tick();
    ob_ex_rw      = regwrite;
    ob_ex_rd      = write_reg;
    ob_ex_alu     = alu_control;
    ob_ex_halted  = halted;
    ob_ex_illegal = illegal;
    tick();
    ob_post_pc      = pc;
    ob_post_instret = instret;
    ob_post_rw      = regwrite;
    ob_post_req     = imem_bus.req;
    ob_post_illegal = illegal;
    ob_post_halted  = halted;
    $display("instr %h at pc %h -> pc %h instret %0d illegal %b halted %b",
             word, ob_addr, ob_post_pc, ob_post_instret, ob_post_illegal, ob_post_halted);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_vec++; if (pc !== 32'h0) begin n_miss++; $display("FAIL rst_pc got=%h want=0", pc); end
    n_vec++; if (instret !== 32'h0) begin n_miss++; $display("FAIL rst_instret got=%h want=0", instret); end
    n_vec++; if (imem_bus.req !== 1'b0) begin n_miss++; $display("FAIL rst_req got=%b want=0", imem_bus.req); end
    n_vec++; if (regwrite !== 1'b0) begin n_miss++; $display("FAIL rst_regwrite got=%b want=0", regwrite); end
    n_vec++; if (alu_control !== 4'b0010) begin n_miss++; $display("FAIL rst_alu got=%b want=0010", alu_control); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_vec++; if (halted !== 1'b0) begin n_miss++; $display("FAIL rst_halted got=%b want=0", halted); end
    n_vec++; if (illegal !== 1'b0) begin n_miss++; $display("FAIL rst_illegal got=%b want=0", illegal); end
    n_vec++; if ({read_reg_num1, read_reg_num2, write_reg} !== 15'h0) begin n_miss++;
      $display("FAIL rst_regnums got=%h/%h/%h want=0", read_reg_num1, read_reg_num2, write_reg); end
    model_pc = 32'h0;
    model_instret = 32'h0;
  endtask

  task automatic test_add();
    pulse_start();
    n_vec++; if (imem_bus.req !== 1'b1 || busy !== 1'b1) begin n_miss++;
      $display("FAIL start_fetch req=%b busy=%b want=1/1", imem_bus.req, busy); end
    sb.push_back(exp_t'{pc: model_pc + 32'd4, instret: model_instret + 32'd1, rw: 1'b1, rd: 5'd3, alu: 4'b0010});
    drive_fetch(32'h002081B3, 1'b0, 0);
    e = sb.pop_front();
    n_vec++; if (ob_dec_rs1 !== 5'd1 || ob_dec_rs2 !== 5'd2) begin n_miss++;
      $display("FAIL add_rs got=%0d/%0d want=1/2", ob_dec_rs1, ob_dec_rs2); end
    n_vec++; if (ob_dec_rw !== 1'b0) begin n_miss++; $display("FAIL add_rw_decode got=%b want=0", ob_dec_rw); end
    n_vec++; if (ob_ex_rw !== e.rw) begin n_miss++; $display("FAIL add_rw_exec got=%b want=%b", ob_ex_rw, e.rw); end
    n_vec++; if (ob_post_rw !== 1'b0) begin n_miss++; $display("FAIL add_rw_after got=%b want=0", ob_post_rw); end
    n_vec++; if (ob_ex_rd !== e.rd) begin n_miss++; $display("FAIL add_rd got=%0d want=%0d", ob_ex_rd, e.rd); end
    n_vec++; if (ob_dec_alu !== e.alu || ob_ex_alu !== e.alu) begin n_miss++;
      $display("FAIL add_alu got=%b/%b want=%b", ob_dec_alu, ob_ex_alu, e.alu); end
    n_vec++; if (ob_post_pc !== e.pc) begin n_miss++; $display("FAIL add_pc got=%h want=%h", ob_post_pc, e.pc); end
    n_vec++; if (ob_post_instret !== e.instret) begin n_miss++;
      $display("FAIL add_instret got=%0d want=%0d", ob_post_instret, e.instret); end
    model_pc = e.pc;
    model_instret = e.instret;
  endtask

  task automatic test_sub_x0();
    sb.push_back(exp_t'{pc: model_pc + 32'd4, instret: model_instret + 32'd1, rw: 1'b0, rd: 5'd0, alu: 4'b0110});
    drive_fetch(32'h40208033, 1'b0, 0);
    e = sb.pop_front();
    n_vec++; if (ob_ex_alu !== e.alu) begin n_miss++; $display("FAIL sub_alu got=%b want=%b", ob_ex_alu, e.alu); end
    n_vec++; if (ob_ex_rw !== e.rw) begin n_miss++; $display("FAIL sub_x0_rw got=%b want=%b", ob_ex_rw, e.rw); end
    n_vec++; if (ob_post_pc !== e.pc) begin n_miss++; $display("FAIL sub_pc got=%h want=%h", ob_post_pc, e.pc); end
    model_pc = e.pc;
    model_instret = e.instret;
  endtask

  task automatic test_branches();
    logic [31:0] words[4] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
    logic        zfs[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        taken[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(exp_t'{pc: model_pc + (taken[i] ? 32'd8 : 32'd4), instret: model_instret + 32'd1,
                          rw: 1'b0, rd: 5'd8, alu: 4'b0110});
      drive_fetch(words[i], zfs[i], 0);
      e = sb.pop_front();
      n_vec++; if (ob_ex_rw !== e.rw) begin n_miss++; $display("FAIL br%0d_rw got=%b want=0", i, ob_ex_rw); end
      n_vec++; if (ob_ex_alu !== e.alu) begin n_miss++; $display("FAIL br%0d_alu got=%b want=%b", i, ob_ex_alu, e.alu); end
      n_vec++; if (ob_post_pc !== e.pc) begin n_miss++; $display("FAIL br%0d_pc got=%h want=%h", i, ob_post_pc, e.pc); end
      n_vec++; if (ob_post_instret !== e.instret) begin n_miss++;
        $display("FAIL br%0d_instret got=%0d want=%0d", i, ob_post_instret, e.instret); end
      model_pc = e.pc;
      model_instret = e.instret;
    end
  endtask

  task automatic test_alu_table();
    logic [6:0] f7s[8]  = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0] f3s[8]  = '{3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b101, 3'b010, 3'b011};
    logic [3:0] alus[8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b0111, 4'b1001};
    for (int i = 0; i < 8; i++) begin
      sb.push_back(exp_t'{pc: model_pc + 32'd4, instret: model_instret + 32'd1, rw: 1'b1, rd: 5'd3, alu: alus[i]});
      drive_fetch({f7s[i], 5'd2, 5'd1, f3s[i], 5'd3, 7'b0110011}, 1'b0, 0);
      e = sb.pop_front();
      n_vec++; if (ob_dec_alu !== e.alu) begin n_miss++; $display("FAIL alu%0d got=%b want=%b", i, ob_dec_alu, e.alu); end
      n_vec++; if (ob_ex_rw !== e.rw) begin n_miss++; $display("FAIL alu%0d_rw got=%b want=1", i, ob_ex_rw); end
      n_vec++; if (ob_post_pc !== e.pc) begin n_miss++; $display("FAIL alu%0d_pc got=%h want=%h", i, ob_post_pc, e.pc); end
      model_pc = e.pc;
      model_instret = e.instret;
    end
  endtask

  task automatic test_wait_states();
    sb.push_back(exp_t'{pc: model_pc + 32'd4, instret: model_instret + 32'd1, rw: 1'b1, rd: 5'd3, alu: 4'b0010});
    drive_fetch(32'h002081B3, 1'b0, 5);
    e = sb.pop_front();
    n_vec++; if (ob_stable !== 1'b1) begin n_miss++; $display("FAIL wait_stable got=%b want=1", ob_stable); end
    n_vec++; if (ob_dec_req !== 1'b0) begin n_miss++; $display("FAIL wait_req_decode got=%b want=0", ob_dec_req); end
    n_vec++; if (ob_post_req !== 1'b1) begin n_miss++; $display("FAIL wait_refetch got=%b want=1", ob_post_req); end
    n_vec++; if (ob_post_pc !== e.pc) begin n_miss++; $display("FAIL wait_pc got=%h want=%h", ob_post_pc, e.pc); end
    n_vec++; if (ob_post_instret !== e.instret) begin n_miss++;
      $display("FAIL wait_instret got=%0d want=%0d", ob_post_instret, e.instret); end
    model_pc = e.pc;
    model_instret = e.instret;
  endtask

  task automatic test_illegal();
    sb.push_back(exp_t'{pc: model_pc, instret: model_instret, rw: 1'b0, rd: 5'd31, alu: 4'b0010});
    drive_fetch(32'hFFFFFFFF, 1'b0, 0);
    e = sb.pop_front();
    n_vec++; if (ob_ex_illegal !== 1'b1 || ob_ex_halted !== 1'b1) begin n_miss++;
      $display("FAIL ill_flags got=%b/%b want=1/1", ob_ex_illegal, ob_ex_halted); end
    n_vec++; if (ob_ex_rw !== e.rw) begin n_miss++; $display("FAIL ill_rw got=%b want=0", ob_ex_rw); end
    n_vec++; if (ob_post_pc !== e.pc) begin n_miss++; $display("FAIL ill_pc got=%h want=%h", ob_post_pc, e.pc); end
    n_vec++; if (ob_post_instret !== e.instret) begin n_miss++;
      $display("FAIL ill_instret got=%0d want=%0d", ob_post_instret, e.instret); end
    n_vec++; if (ob_post_req !== 1'b0 || ob_post_illegal !== 1'b1) begin n_miss++;
      $display("FAIL ill_hold req=%b illegal=%b want=0/1", ob_post_req, ob_post_illegal); end
    pulse_start();
    n_vec++; if (illegal !== 1'b0 || halted !== 1'b0) begin n_miss++;
      $display("FAIL restart_flags illegal=%b halted=%b want=0/0", illegal, halted); end
    n_vec++; if (pc !== 32'h0) begin n_miss++; $display("FAIL restart_pc got=%h want=0", pc); end
    n_vec++; if (imem_bus.req !== 1'b1 || busy !== 1'b1) begin n_miss++;
      $display("FAIL restart_fetch req=%b busy=%b want=1/1", imem_bus.req, busy); end
    model_pc = 32'h0;
  endtask

  task automatic test_misaligned_and_ecall();
    // BEQ with offset 6 taken from pc 0: target bit1 set
    sb.push_back(exp_t'{pc: model_pc, instret: model_instret, rw: 1'b0, rd: 5'd6, alu: 4'b0110});
    drive_fetch(32'h00208363, 1'b1, 0);
    e = sb.pop_front();
    n_vec++; if (ob_ex_halted !== 1'b0) begin n_miss++; $display("FAIL mis_exec_halted got=%b want=0", ob_ex_halted); end
    n_vec++; if (ob_post_illegal !== 1'b1 || ob_post_halted !== 1'b1) begin n_miss++;
      $display("FAIL mis_flags got=%b/%b want=1/1", ob_post_illegal, ob_post_halted); end
    n_vec++; if (ob_post_pc !== e.pc) begin n_miss++; $display("FAIL mis_pc got=%h want=%h", ob_post_pc, e.pc); end
    n_vec++; if (ob_post_instret !== e.instret) begin n_miss++;
      $display("FAIL mis_instret got=%0d want=%0d", ob_post_instret, e.instret); end
    pulse_start();
    sb.push_back(exp_t'{pc: 32'h0, instret: model_instret, rw: 1'b0, rd: 5'd0, alu: 4'b0010});
    drive_fetch(32'h00000073, 1'b0, 0);
    e = sb.pop_front();
    n_vec++; if (ob_post_halted !== 1'b1 || ob_post_illegal !== 1'b0) begin n_miss++;
      $display("FAIL ecall_flags halted=%b illegal=%b want=1/0", ob_post_halted, ob_post_illegal); end
    n_vec++; if (ob_post_instret !== e.instret || ob_post_pc !== e.pc) begin n_miss++;
      $display("FAIL ecall_state pc=%h instret=%0d want=%h/%0d", ob_post_pc, ob_post_instret, e.pc, e.instret); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    imem_bus.ack = 1'b0;
    tick();
    // Reset and ack coincide: the ack must be discarded
    reset = 1'b1;
    imem_bus.rdata = 32'h002081B3;
    imem_bus.ack = 1'b1;
    tick();
    reset = 1'b0;
    imem_bus.ack = 1'b0;
    n_vec++; if (imem_bus.req !== 1'b0 || busy !== 1'b0) begin n_miss++;
      $display("FAIL rstf_req req=%b busy=%b want=0/0", imem_bus.req, busy); end
    n_vec++; if (read_reg_num1 !== 5'd0 || write_reg !== 5'd0 || alu_control !== 4'b0010) begin n_miss++;
      $display("FAIL rstf_ir rs1=%0d rd=%0d alu=%b want=0/0/0010", read_reg_num1, write_reg, alu_control); end
    n_vec++; if (pc !== 32'h0 || instret !== 32'h0 || illegal !== 1'b0) begin n_miss++;
      $display("FAIL rstf_state pc=%h instret=%0d illegal=%b want=0", pc, instret, illegal); end
    tick();
    n_vec++; if (imem_bus.req !== 1'b0) begin n_miss++; $display("FAIL rstf_idle req=%b want=0", imem_bus.req); end
    // Retire one instruction so the mid-EXECUTE reset has state to clear
    pulse_start();
    drive_fetch(32'h002081B3, 1'b0, 0);
    imem_bus.rdata = 32'h002081B3;
    imem_bus.ack = 1'b1;
    tick();
    imem_bus.ack = 1'b0;
    tick();
    n_vec++; if (regwrite !== 1'b1) begin n_miss++; $display("FAIL rste_pre_rw got=%b want=1", regwrite); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (regwrite !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin n_miss++;
      $display("FAIL rste_ctrl rw=%b busy=%b halted=%b want=0/0/0", regwrite, busy, halted); end
    n_vec++; if (pc !== 32'h0 || instret !== 32'h0) begin n_miss++;
      $display("FAIL rste_state pc=%h instret=%0d want=0/0", pc, instret); end
    n_vec++; if (write_reg !== 5'd0 || imem_bus.req !== 1'b0) begin n_miss++;
      $display("FAIL rste_outs rd=%0d req=%b want=0/0", write_reg, imem_bus.req); end
  endtask

  initial begin
    imem_bus.ack = 1'b0;
    imem_bus.rdata = 32'h0;
    test_reset();
    test_add();
    test_sub_x0();
    test_branches();
    test_alu_table();
    test_wait_states();
    test_illegal();
    test_misaligned_and_ecall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
